mixn_tdm: RTL
=============

# mixn_tdm

Time-multiplexed N-channel digital down-conversion mixer. One ADC sample is mixed against NCH independent numerically controlled oscillators (NCOs), processing one channel per clock. The result is a stream of rounded, saturated I/Q products tagged with a channel index. It sits between the ADC capture register and the per-channel CIC decimators, and replaces the fixed two-channel, two-clock mixer with a single-clock, parameterised design.

## Interface
- NCH, 2: number of receive channels; 1..16.
- ADC_W, 12: ADC sample width, signed.
- PHASE_W, 32: phase accumulator and increment width.
- LUT_AW, 10: quarter-wave LUT address width.
- SIN_W, 18: sine/cosine amplitude width, signed; full scale is 2^(SIN_W-1)-1.
- OUT_W, 18: output I/Q width, signed.
- SHIFT, 11: arithmetic right shift applied to the product before rounding.
- clk  in  1  single clock; runs at no less than NCH times the ADC sample rate.
- rst  in  1  asynchronous, active-high reset.
- adc  in  ADC_W  signed ADC sample; sampled when adc_valid=1.
- adc_valid  in  1  one-cycle strobe marking a new sample.
- phi  in  NCH*PHASE_W  per-channel phase increments; channel c occupies bits [c*PHASE_W +: PHASE_W].
- phase_clr  in  1  synchronous clear of all phase accumulators.
- out_i, out_q  out  OUT_W  mixed I (uses cos) and Q (uses sin).
- out_chan  out  clog2(NCH) (minimum 1)  channel index of the current output.
- out_valid  out  1  qualifies out_i, out_q and out_chan.
- overrun  out  1  sticky flag; set when a sample is dropped.

## Operation
- Idle: adc_valid=1 latches adc and starts a sweep. The sweep issues channels 0..NCH-1 in consecutive cycles, starting the cycle after acceptance.
- Busy: adc_valid=1 while a sweep has slots left to issue drops that sample and sets overrun. A strobe arriving in the same cycle as the final slot is accepted, so back-to-back sweeps are possible at exactly NCH cycles per sample.
- Per slot c:
  - Phase used is acc[c] before the update.
  - acc[c] is then updated to acc[c] + phi[c], wrapping mod 2^PHASE_W.
  - phi[c] is read in the slot cycle.
- Sin/cos lookup:
  - Address is the top LUT_AW+2 phase bits; remaining bits are truncated, with no dither.
  - Quadrant bits mirror and negate a quarter-wave ROM.
  - Entry i = round((2^(SIN_W-1)-1)·sin(π·i/2^(LUT_AW+1))).
  - A mirrored address equal to 2^LUT_AW returns full scale.
- Multiply: adc (ADC_W) × cos or sin (SIN_W) gives an ADC_W+SIN_W-bit signed product.
- Round: add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up.
- Saturate: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- phase_clr=1 zeroes every acc in the next cycle and takes priority over any update in that cycle. Sweeps in flight continue using the cleared values.
- Reset, including reset mid-sweep:
  - Sweep is aborted and the pipeline is flushed.
  - All acc are cleared to 0.
  - out_i=0, out_q=0, out_chan=0, out_valid=0, overrun=0.
- overrun clears only on rst.

## Timing
- adc_valid is accepted at edge k.
- Slot c is issued at cycle k+1+c.
- Pipeline stages:
  - Phase register (1 cycle).
  - LUT (2 cycles).
  - Multiply (1 cycle).
  - Round/saturate (1 cycle).
  - Output register (1 cycle).
- Output for channel c: out_valid is high in cycle k+7+c, so LAT=6 cycles from issue.
- out_valid is high for exactly NCH consecutive cycles per accepted sample, with out_chan ascending 0..NCH-1.
- Output holds its last value while out_valid=0.
- Throughput is one accepted sample per NCH cycles.

## Structure
- Package mixn_pkg holds:
  - LAT constant (6).
  - Channel-index width function.
  - Round/saturate function, parameterised by input width, SHIFT and OUT_W.
- Sub-module sincos_lut:
  - Input: phase of LUT_AW+2 bits.
  - Output: signed SIN_W sin/cos.
  - Fixed 2-cycle latency.
  - ROM generated at elaboration.
- Top level holds:
  - Sweep FSM (IDLE/SWEEP).
  - Channel counter.
  - Accumulator array.
  - Multiply and round/saturate pipeline.
  - Valid/channel delay line.

## Test plan
- Reset and first sample:
  - Setup: NCH=2, phi=0, adc=1000, one strobe after reset.
  - Expected: two outputs at k+7 and k+8, each with out_i=64000 and out_q=0.
  - Check: 1000·131071/2048 = 63999.51, which rounds to 64000.
- Quarter-turn phase stepping:
  - Setup: NCH=1, phi=2^30, adc=1000, strobes every cycle.
  - Expected: out_i sequence 64000, 0, -64000, 0, 64000; out_q sequence 0, 64000, 0, -64000.
  - Demonstrates wrap at 2^32.
- Saturation:
  - Setup: SHIFT=10, adc=-2048, phi=0.
  - Expected: out_i=-131072 (clamped from -262142).
  - Setup: adc=2047.
  - Expected: out_i=131071.
- Overrun:
  - Setup: NCH=4, strobes at k and k+2.
  - Expected: second sample dropped, overrun=1, exactly 4 valid outputs.
  - Setup: strobe at k+4 (final slot).
  - Expected: accepted with no gap in out_valid.
- phase_clr and reset mid-sweep:
  - Setup: phase_clr pulsed after 5 samples with phi=2^30.
  - Expected: next slot uses phase 0 (out_i=64000).
  - Setup: rst asserted in cycle k+2 of a sweep.
  - Expected: out_valid stays 0, all outputs 0, and the next sweep restarts from phase 0.
- Per-channel independence:
  - Setup: NCH=3 with phi = {0, 2^31, 2^30}.
  - Expected (channels 0/1/2), first sample: out_i = 64000 / 64000 / 64000.
  - Expected, second sample: out_i = 64000 / -64000 / 0.

Source files
------------

// File: rtl/mixn_pkg.sv
// Shared constants, types and arithmetic helpers for the time-multiplexed mixer.
package mixn_pkg;

   localparam int LAT = 6;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   function automatic int chanWidth(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Round half-up then clamp; raw carries an inW-bit signed value in its low bits.
   function automatic logic signed [63:0] roundSat(input logic [63:0] raw,
                                                   input int inW,
                                                   input int shift,
                                                   input int outW);
      logic signed [63:0] x;
      logic signed [63:0] r;
      logic signed [63:0] maxV;
      logic signed [63:0] minV;
      x    = signed'(raw << (64 - inW)) >>> (64 - inW);
      r    = (shift > 0) ? ((x + (64'sd1 <<< (shift - 1))) >>> shift) : x;
      maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
      minV = -(64'sd1 <<< (outW - 1));
      if (r > maxV) begin
         return maxV;
      end
      if (r < minV) begin
         return minV;
      end
      return r;
   endfunction

endpackage

// File: rtl/sincos_lut.sv
// Quarter-wave sine/cosine lookup with a fixed two-cycle latency.
// The ROM holds 2^LUT_AW+1 entries so the mirrored address 2^LUT_AW lands on full scale.
module sincos_lut #(
   parameter int LUT_AW = 10,
   parameter int SIN_W  = 18
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LUT_AW+1:0]       i_phase,
   output logic signed [SIN_W-1:0] o_sin,
   output logic signed [SIN_W-1:0] o_cos
);
   localparam int  N  = 1 << LUT_AW;
   localparam real PI = 3.14159265358979323846;
   localparam real FS = (2.0 ** (SIN_W - 1)) - 1.0;

   logic [SIN_W-2:0] w_rom [N+1];

   for (genvar gi = 0; gi <= N; gi++) begin : g_rom
      localparam int VAL = $rtoi(FS * $sin(PI * real'(gi) / real'(2 * N)) + 0.5);
      assign w_rom[gi] = (SIN_W - 1)'(VAL);
   end

   logic [1:0]        w_quad;
   logic [LUT_AW:0]   w_fwd;
   logic [LUT_AW:0]   w_mir;
   logic [LUT_AW:0]   r_sinAddr;
   logic [LUT_AW:0]   r_cosAddr;
   logic              r_sinNeg;
   logic              r_cosNeg;
   logic signed [SIN_W-1:0] w_sinMag;
   logic signed [SIN_W-1:0] w_cosMag;

   assign w_quad = i_phase[LUT_AW+1:LUT_AW];
   assign w_fwd  = {1'b0, i_phase[LUT_AW-1:0]};
   assign w_mir  = (LUT_AW + 1)'(N) - w_fwd;

   // Cosine is sine advanced one quadrant, so its mirror/negate pattern is rotated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sinAddr <= '0;
         r_cosAddr <= '0;
         r_sinNeg  <= 1'b0;
         r_cosNeg  <= 1'b0;
      end else begin
         r_sinAddr <= w_quad[0] ? w_mir : w_fwd;
         r_cosAddr <= w_quad[0] ? w_fwd : w_mir;
         r_sinNeg  <= w_quad[1];
         r_cosNeg  <= w_quad[1] ^ w_quad[0];
      end
   end

   assign w_sinMag = {1'b0, w_rom[r_sinAddr]};
   assign w_cosMag = {1'b0, w_rom[r_cosAddr]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_sin <= '0;
         o_cos <= '0;
      end else begin
         o_sin <= r_sinNeg ? -w_sinMag : w_sinMag;
         o_cos <= r_cosNeg ? -w_cosMag : w_cosMag;
      end
   end

endmodule

// File: rtl/mixn_tdm.sv
// N-channel digital down-conversion mixer: one ADC sample is swept across NCH
// independent NCOs, one channel per clock, producing rounded and saturated I/Q.
module mixn_tdm
   import mixn_pkg::*;
#(
   parameter int  NCH     = 2,
   parameter int  ADC_W   = 12,
   parameter int  PHASE_W = 32,
   parameter int  LUT_AW  = 10,
   parameter int  SIN_W   = 18,
   parameter int  OUT_W   = 18,
   parameter int  SHIFT   = 11,
   localparam int CH_W    = chanWidth(NCH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [ADC_W-1:0]  i_adc,
   input  logic                     i_adc_valid,
   input  logic [NCH*PHASE_W-1:0]   i_phi,
   input  logic                     i_phase_clr,
   output logic signed [OUT_W-1:0]  o_out_i,
   output logic signed [OUT_W-1:0]  o_out_q,
   output logic [CH_W-1:0]          o_out_chan,
   output logic                     o_out_valid,
   output logic                     o_overrun
);
   localparam int              PA_W   = LUT_AW + 2;
   localparam int              PROD_W = ADC_W + SIN_W;
   localparam logic [CH_W-1:0] LAST   = CH_W'(NCH - 1);

   sweep_state_t            r_state;
   logic [CH_W-1:0]         r_cnt;
   logic signed [ADC_W-1:0] r_adc;
   logic [PHASE_W-1:0]      r_acc [NCH];
   logic                    w_issue;

   assign w_issue = (r_state == SWEEP);

   // A strobe on the final slot starts the next sweep directly, giving NCH cycles per sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_adc     <= '0;
         o_overrun <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_adc_valid) begin
                  r_state <= SWEEP;
                  r_cnt   <= '0;
                  r_adc   <= i_adc;
               end
            end
            SWEEP: begin
               if (r_cnt == LAST) begin
                  if (i_adc_valid) begin
                     r_cnt <= '0;
                     r_adc <= i_adc;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (i_adc_valid) begin
                     o_overrun <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Clearing wins over the slot update landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_acc[c] <= '0;
         end
      end else if (i_phase_clr) begin
         for (int c = 0; c < NCH; c++) begin
            r_acc[c] <= '0;
         end
      end else if (w_issue) begin
         r_acc[r_cnt] <= r_acc[r_cnt] + i_phi[r_cnt*PHASE_W +: PHASE_W];
      end
   end

   logic [PA_W-1:0]          r_ph;
   logic signed [ADC_W-1:0]  r_adcDly [3];
   logic signed [SIN_W-1:0]  w_sin;
   logic signed [SIN_W-1:0]  w_cos;
   logic signed [PROD_W-1:0] r_prodI;
   logic signed [PROD_W-1:0] r_prodQ;
   logic signed [OUT_W-1:0]  r_rsI;
   logic signed [OUT_W-1:0]  r_rsQ;

   sincos_lut #(
      .LUT_AW (LUT_AW),
      .SIN_W  (SIN_W)
   ) u_lut (
      .clk     (clk),
      .rst     (rst),
      .i_phase (r_ph),
      .o_sin   (w_sin),
      .o_cos   (w_cos)
   );

   // The sample rides alongside its phase so a new sweep can overwrite r_adc early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph <= '0;
         for (int s = 0; s < 3; s++) begin
            r_adcDly[s] <= '0;
         end
         r_prodI <= '0;
         r_prodQ <= '0;
         r_rsI   <= '0;
         r_rsQ   <= '0;
      end else begin
         r_ph        <= r_acc[r_cnt][PHASE_W-1 -: PA_W];
         r_adcDly[0] <= r_adc;
         r_adcDly[1] <= r_adcDly[0];
         r_adcDly[2] <= r_adcDly[1];
         r_prodI     <= PROD_W'(r_adcDly[2]) * PROD_W'(w_cos);
         r_prodQ     <= PROD_W'(r_adcDly[2]) * PROD_W'(w_sin);
         r_rsI       <= OUT_W'(roundSat(64'(r_prodI), PROD_W, SHIFT, OUT_W));
         r_rsQ       <= OUT_W'(roundSat(64'(r_prodQ), PROD_W, SHIFT, OUT_W));
      end
   end

   logic [LAT-2:0]  r_vDly;
   logic [CH_W-1:0] r_chDly [LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vDly <= '0;
         for (int s = 0; s < LAT - 1; s++) begin
            r_chDly[s] <= '0;
         end
         o_out_valid <= 1'b0;
         o_out_chan  <= '0;
         o_out_i     <= '0;
         o_out_q     <= '0;
      end else begin
         r_vDly     <= {r_vDly[LAT-3:0], w_issue};
         r_chDly[0] <= r_cnt;
         for (int s = 1; s < LAT - 1; s++) begin
            r_chDly[s] <= r_chDly[s-1];
         end
         o_out_valid <= r_vDly[LAT-2];
         if (r_vDly[LAT-2]) begin
            o_out_chan <= r_chDly[LAT-2];
            o_out_i    <= r_rsI;
            o_out_q    <= r_rsQ;
         end
      end
   end

endmodule
